vec_mod_engine: RTL

Parametrised successor to the fixed three-unit coprocessor datapath. It holds a REGS-entry register file of LANES×W-bit residue vectors and executes one vector command at a time (ADD, SUB, MUL, COPY mod p) through P_LANES shared lane ALUs, P_LANES lanes per beat. Commands arrive on a valid/ready handshake, and writeback is atomic. It sits between the host command interface and the coprocessor register storage.

---
 rtl/vec_mod_pkg.sv | 30 +++
 rtl/mod_lane_alu.sv | 100 ++++++++++
 rtl/vec_mod_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vec_mod_pkg.sv
// Shared types and elaboration helpers for the vector modular-arithmetic engine.
package vec_mod_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_COPY = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EXEC  = 2'b01,
      ST_DRAIN = 2'b10,
      ST_WB    = 2'b11
   } state_e;

   function automatic int beats(input int lanes, input int p_lanes);
      return lanes / p_lanes;
   endfunction

   function automatic int op_lat(input op_e op, input int mul_lat);
      return (op == OP_MUL) ? mul_lat : 1;
   endfunction

   function automatic bit lanes_ok(input int lanes, input int p_lanes);
      return (p_lanes > 0) && ((lanes % p_lanes) == 0);
   endfunction

endpackage

// File: rtl/mod_lane_alu.sv
// One W-bit lane: modular add/sub/copy and Barrett multiply, result delayed
// through a MUL_LAT-deep register chain with a matching valid tag.
module mod_lane_alu
   import vec_mod_pkg::*;
#(
   parameter int W       = 32,
   parameter int MUL_LAT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] mod_p,
   input  logic [W:0]   mod_rec,
   output logic         out_vld,
   output logic [W-1:0] out_res
);

   logic [W:0]         sum_s;
   logic [W:0]         dif_s;
   logic [2*W-1:0]     x_s;
   logic [W:0]         xs_s;
   logic [2*W+1:0]     prod_s;
   logic [W:0]         q_s;
   logic [W+1:0]       p_ext_s;
   logic [W+1:0]       qp_s;
   logic [W+1:0]       r0_s;
   logic [W+1:0]       r1_s;
   logic [W+1:0]       r2_s;
   logic [W-1:0]       res_s;
   logic [W-1:0]       pipe_q [MUL_LAT];
   logic [W-1:0]       pipe_d [MUL_LAT];
   logic [MUL_LAT-1:0] vld_q;
   logic [MUL_LAT-1:0] vld_d;

   // Lane arithmetic; the Barrett remainder is below 3p, so W+2 bits suffice.
   always_comb begin
      sum_s   = {1'b0, a} + {1'b0, b};
      dif_s   = {1'b0, a} - {1'b0, b};
      x_s     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      xs_s    = x_s[2*W-1:W-1];
      prod_s  = {{(W+1){1'b0}}, xs_s} * {{(W+1){1'b0}}, mod_rec};
      q_s     = (W+1)'(prod_s >> (W+1));
      p_ext_s = {2'b00, mod_p};
      qp_s    = {1'b0, q_s} * p_ext_s;
      r0_s    = x_s[W+1:0] - qp_s;
      if (r0_s >= p_ext_s) r1_s = r0_s - p_ext_s;
      else                 r1_s = r0_s;
      if (r1_s >= p_ext_s) r2_s = r1_s - p_ext_s;
      else                 r2_s = r1_s;
      case (op)
         OP_ADD: begin
            if (sum_s >= {1'b0, mod_p}) res_s = W'(sum_s - {1'b0, mod_p});
            else                        res_s = sum_s[W-1:0];
         end
         OP_SUB: begin
            if (dif_s[W]) res_s = dif_s[W-1:0] + mod_p;
            else          res_s = dif_s[W-1:0];
         end
         OP_MUL:  res_s = W'(r2_s);
         OP_COPY: res_s = a;
         default: res_s = a;
      endcase
   end

   // Delay chain feeding the selected tap.
   always_comb begin
      pipe_d[0] = res_s;
      vld_d[0]  = in_vld;
      for (int k = 1; k < MUL_LAT; k++) begin
         pipe_d[k] = pipe_q[k-1];
         vld_d[k]  = vld_q[k-1];
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= {MUL_LAT{1'b0}};
         for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= {W{1'b0}};
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= pipe_d[k];
      end
   end

   // Tap chosen by the op latency.
   always_comb begin
      if (op_lat(op, MUL_LAT) == 1) begin
         out_vld = vld_q[0];
         out_res = pipe_q[0];
      end else begin
         out_vld = vld_q[MUL_LAT-1];
         out_res = pipe_q[MUL_LAT-1];
      end
   end

endmodule

// File: rtl/vec_mod_engine.sv
// Vector modular-arithmetic engine: register file of residue vectors, one
// command at a time through P_LANES shared lane ALUs, atomic writeback.
module vec_mod_engine
   import vec_mod_pkg::*;
#(
   parameter int W       = 32,
   parameter int LANES   = 32,
   parameter int P_LANES = 4,
   parameter int REGS    = 32,
   parameter int MUL_LAT = 3,
   localparam int AW     = $clog2(REGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W-1:0]         mod_p,
   input  logic [W:0]           mod_rec,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [AW-1:0]        cmd_src1,
   input  logic [AW-1:0]        cmd_src2,
   input  logic [AW-1:0]        cmd_dst,
   output logic                 busy,
   output logic                 done,
   input  logic                 host_we,
   input  logic [AW-1:0]        host_waddr,
   input  logic [W*LANES-1:0]   host_wdata,
   output logic                 wr_err,
   input  logic [AW-1:0]        host_raddr,
   output logic [W*LANES-1:0]   host_rdata
);

   localparam int VW    = W * LANES;
   localparam int BEATS = beats(LANES, P_LANES);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   if (!lanes_ok(LANES, P_LANES)) begin : g_lanes_check
      $error("vec_mod_engine: LANES must be a multiple of P_LANES");
   end

   state_e          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d, cap_q, cap_d;
   op_e             op_q, op_d;
   logic [AW-1:0]   dst_q, dst_d;
   logic [W-1:0]    p_q, p_d;
   logic [W:0]      rec_q, rec_d;
   logic [VW-1:0]   src1_q, src1_d, src2_q, src2_d, res_buf_q, res_buf_d;
   logic            done_q, done_d, wr_err_q, wr_err_d;
   logic [VW-1:0]   rdata_q, rdata_d;
   logic [VW-1:0]   rf_q [REGS];
   logic            rf_we_s;
   logic [AW-1:0]   rf_waddr_s;
   logic [VW-1:0]   rf_wdata_s;
   logic [W-1:0]    lane_a_s [P_LANES];
   logic [W-1:0]    lane_b_s [P_LANES];
   logic [W-1:0]    lane_res_s [P_LANES];
   logic [P_LANES-1:0] lane_vld_s;
   logic            alu_in_vld_s;
   logic            alu_vld_s;

   for (genvar i = 0; i < P_LANES; i++) begin : g_lane
      assign lane_a_s[i] = src1_q[(int'(beat_q) * P_LANES + i) * W +: W];
      assign lane_b_s[i] = src2_q[(int'(beat_q) * P_LANES + i) * W +: W];
      mod_lane_alu #(.W(W), .MUL_LAT(MUL_LAT)) u_alu (
         .clk     (clk),
         .rst_n   (rst_n),
         .in_vld  (alu_in_vld_s),
         .op      (op_q),
         .a       (lane_a_s[i]),
         .b       (lane_b_s[i]),
         .mod_p   (p_q),
         .mod_rec (rec_q),
         .out_vld (lane_vld_s[i]),
         .out_res (lane_res_s[i])
      );
   end

   assign alu_vld_s = &lane_vld_s;

   // Next-state, snapshot, result capture and register-file write selection.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      cap_d        = cap_q;
      op_d         = op_q;
      dst_d        = dst_q;
      p_d          = p_q;
      rec_d        = rec_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      res_buf_d    = res_buf_q;
      done_d       = 1'b0;
      wr_err_d     = host_we && (state_q != ST_IDLE);
      rdata_d      = rf_q[host_raddr];
      rf_we_s      = 1'b0;
      rf_waddr_s   = host_waddr;
      rf_wdata_s   = host_wdata;
      alu_in_vld_s = 1'b0;

      if (alu_vld_s) begin
         for (int i = 0; i < P_LANES; i++) begin
            res_buf_d[(int'(cap_q) * P_LANES + i) * W +: W] = lane_res_s[i];
         end
         if (cap_q == LAST_BEAT) cap_d = {BW{1'b0}};
         else                    cap_d = cap_q + BW'(1);
      end else begin
         cap_d = cap_q;
      end

      case (state_q)
         ST_IDLE: begin
            rf_we_s = host_we;
            // Snapshot reads the pre-edge contents, so a coincident host write is not seen.
            if (cmd_valid) begin
               src1_d  = rf_q[cmd_src1];
               src2_d  = rf_q[cmd_src2];
               op_d    = op_e'(cmd_op);
               dst_d   = cmd_dst;
               p_d     = mod_p;
               rec_d   = mod_rec;
               beat_d  = {BW{1'b0}};
               cap_d   = {BW{1'b0}};
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            alu_in_vld_s = 1'b1;
            if (beat_q == LAST_BEAT) begin
               beat_d  = {BW{1'b0}};
               state_d = ST_DRAIN;
            end else begin
               beat_d  = beat_q + BW'(1);
               state_d = ST_EXEC;
            end
         end
         ST_DRAIN: begin
            if (alu_vld_s && (cap_q == LAST_BEAT)) state_d = ST_WB;
            else                                   state_d = ST_DRAIN;
         end
         ST_WB: begin
            rf_we_s    = 1'b1;
            rf_waddr_s = dst_q;
            rf_wdata_s = res_buf_q;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         beat_q    <= {BW{1'b0}};
         cap_q     <= {BW{1'b0}};
         op_q      <= OP_ADD;
         dst_q     <= {AW{1'b0}};
         p_q       <= {W{1'b0}};
         rec_q     <= {(W+1){1'b0}};
         src1_q    <= {VW{1'b0}};
         src2_q    <= {VW{1'b0}};
         res_buf_q <= {VW{1'b0}};
         done_q    <= 1'b0;
         wr_err_q  <= 1'b0;
         rdata_q   <= {VW{1'b0}};
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         cap_q     <= cap_d;
         op_q      <= op_d;
         dst_q     <= dst_d;
         p_q       <= p_d;
         rec_q     <= rec_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         res_buf_q <= res_buf_d;
         done_q    <= done_d;
         wr_err_q  <= wr_err_d;
         rdata_q   <= rdata_d;
      end
   end

   // Register file storage; deliberately not reset.
   always_ff @(posedge clk) begin
      if (rf_we_s) rf_q[rf_waddr_s] <= rf_wdata_s;
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign busy       = ~cmd_ready;
   assign done       = done_q;
   assign wr_err     = wr_err_q;
   assign host_rdata = rdata_q;

endmodule
